// File: rtl/zbb_seq_unit.sv
// Handshaked Zbb execute unit: single-cycle bitwise/min/max/sext/byte ops, iterative clz/ctz/cpop.
// Optional rotates (rol/ror/rori) are built only when ZBB_ROT_EN is defined.
//
// state  | meaning
// S_IDLE | ready to accept an instruction
// S_SCAN | clz/ctz/cpop consuming one SCAN-bit chunk per cycle
// S_DONE | result presented, waiting for out_ready
module zbb_seq_unit #(
  parameter int XLEN = 32,
  parameter int SCAN = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      cmdOp,
  input  logic [2:0]      cmdF3,
  input  logic [6:0]      cmdF7,
  input  logic [11:0]     immI,
  input  logic [XLEN-1:0] din_rs1,
  input  logic [XLEN-1:0] din_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] dout_rd,
  output logic            out_illeg
);

  localparam int NCHUNK = XLEN / SCAN;
  localparam int CW     = $clog2(XLEN + 1);
  localparam int CCW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SW     = $clog2(XLEN);
  localparam logic [11:0] REV8_IMM = (XLEN == 64) ? 12'h6B8 : 12'h698;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} stateT;
  typedef enum logic [4:0] {
    K_ANDN, K_ORN, K_XNOR, K_MIN, K_MINU, K_MAX, K_MAXU,
    K_CLZ, K_CTZ, K_CPOP, K_SEXTB, K_SEXTH, K_ORCB, K_REV8,
    K_ROL, K_ROR, K_RORI, K_ILLEG
  } kindT;

  stateT state, stateNext;
  kindT  kind;

  logic [XLEN-1:0] singleRes;
  logic [XLEN-1:0] resultReg;
  logic            illegReg;
  logic [XLEN-1:0] scanReg;
  logic [CW-1:0]   cntReg;
  logic [CW-1:0]   cntNext;
  logic [CW-1:0]   chunkVal;
  logic [CCW-1:0]  chunksLeft;
  logic            popMode;
  logic [SCAN-1:0] chunk;
  logic            scanDone;
  logic            accept;
  logic            isScanOp;

  function automatic logic [CW-1:0] lzCnt(input logic [SCAN-1:0] c);
    logic [CW-1:0] n;
    logic found;
    n = '0;
    found = 1'b0;
    for (int i = SCAN - 1; i >= 0; i--) begin
      if (!found) begin
        if (c[i]) found = 1'b1;
        else      n = n + CW'(1);
      end
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] popCnt(input logic [SCAN-1:0] c);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < SCAN; i++) n = n + CW'(c[i]);
    return n;
  endfunction

  // ctz reuses the MSB-first scan on the bit-reversed operand
  function automatic logic [XLEN-1:0] bitRev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction

`ifdef ZBB_ROT_EN
  logic roriMatch;
  assign roriMatch = (XLEN == 64) ? (immI[11:6] == 6'b011000) : (immI[11:5] == 7'b0110000);
`endif

  always_comb begin
    kind = K_ILLEG;
    if (cmdOp == 7'b0110011) begin
      if (cmdF7 == 7'b0100000) begin
        case (cmdF3)
          3'b111:  kind = K_ANDN;
          3'b110:  kind = K_ORN;
          3'b100:  kind = K_XNOR;
          default: kind = K_ILLEG;
        endcase
      end else if (cmdF7 == 7'b0000101) begin
        case (cmdF3)
          3'b100:  kind = K_MIN;
          3'b101:  kind = K_MINU;
          3'b110:  kind = K_MAX;
          3'b111:  kind = K_MAXU;
          default: kind = K_ILLEG;
        endcase
      end
`ifdef ZBB_ROT_EN
      else if (cmdF7 == 7'b0110000) begin
        case (cmdF3)
          3'b001:  kind = K_ROL;
          3'b101:  kind = K_ROR;
          default: kind = K_ILLEG;
        endcase
      end
`endif
    end else if (cmdOp == 7'b0010011) begin
      if (cmdF3 == 3'b001) begin
        case (immI)
          12'h600: kind = K_CLZ;
          12'h601: kind = K_CTZ;
          12'h602: kind = K_CPOP;
          12'h604: kind = K_SEXTB;
          12'h605: kind = K_SEXTH;
          default: kind = K_ILLEG;
        endcase
      end else if (cmdF3 == 3'b101) begin
        if (immI == 12'h287)         kind = K_ORCB;
        else if (immI == REV8_IMM)   kind = K_REV8;
`ifdef ZBB_ROT_EN
        else if (roriMatch)          kind = K_RORI;
`endif
      end
    end
  end

  assign isScanOp = (kind == K_CLZ) || (kind == K_CTZ) || (kind == K_CPOP);

`ifdef ZBB_ROT_EN
  logic [SW-1:0]   rotAmt;
  logic [SW-1:0]   rorAmt;
  logic [XLEN-1:0] rotRes;
  // rol by s is ror by (-s mod XLEN); a shift by XLEN yields 0, covering s=0
  always_comb begin
    rotAmt = (kind == K_RORI) ? immI[SW-1:0] : din_rs2[SW-1:0];
    rorAmt = (kind == K_ROL) ? (SW'(0) - rotAmt) : rotAmt;
    rotRes = (din_rs1 >> rorAmt) | (din_rs1 << ((SW+1)'(XLEN) - {1'b0, rorAmt}));
  end
`endif

  always_comb begin
    singleRes = '0;
    case (kind)
      K_ANDN:  singleRes = din_rs1 & ~din_rs2;
      K_ORN:   singleRes = din_rs1 | ~din_rs2;
      K_XNOR:  singleRes = ~(din_rs1 ^ din_rs2);
      K_MIN:   singleRes = ($signed(din_rs1) <= $signed(din_rs2)) ? din_rs1 : din_rs2;
      K_MINU:  singleRes = (din_rs1 <= din_rs2) ? din_rs1 : din_rs2;
      K_MAX:   singleRes = ($signed(din_rs1) >= $signed(din_rs2)) ? din_rs1 : din_rs2;
      K_MAXU:  singleRes = (din_rs1 >= din_rs2) ? din_rs1 : din_rs2;
      K_SEXTB: singleRes = {{(XLEN-8){din_rs1[7]}}, din_rs1[7:0]};
      K_SEXTH: singleRes = {{(XLEN-16){din_rs1[15]}}, din_rs1[15:0]};
      K_ORCB: begin
        for (int i = 0; i < XLEN / 8; i++)
          singleRes[8*i +: 8] = (|din_rs1[8*i +: 8]) ? 8'hFF : 8'h00;
      end
      K_REV8: begin
        for (int i = 0; i < XLEN / 8; i++)
          singleRes[8*i +: 8] = din_rs1[XLEN-8-8*i +: 8];
      end
`ifdef ZBB_ROT_EN
      K_ROL, K_ROR, K_RORI: singleRes = rotRes;
`endif
      default: singleRes = '0;
    endcase
  end

  assign chunk    = scanReg[XLEN-1 -: SCAN];
  assign chunkVal = popMode ? popCnt(chunk) : lzCnt(chunk);
  assign cntNext  = cntReg + chunkVal;
  assign scanDone = (chunksLeft == '0) || (!popMode && (chunk != '0));
  assign accept   = in_valid && (state == S_IDLE) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (flush) begin
      stateNext = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (in_valid) stateNext = isScanOp ? S_SCAN : S_DONE;
        S_SCAN:  if (scanDone) stateNext = S_DONE;
        S_DONE:  if (out_ready) stateNext = S_IDLE;
        default: stateNext = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultReg  <= '0;
      illegReg   <= 1'b0;
      scanReg    <= '0;
      cntReg     <= '0;
      chunksLeft <= '0;
      popMode    <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        scanReg    <= (kind == K_CTZ) ? bitRev(din_rs1) : din_rs1;
        cntReg     <= '0;
        chunksLeft <= CCW'(NCHUNK - 1);
        popMode    <= (kind == K_CPOP);
        resultReg  <= singleRes;
        illegReg   <= (kind == K_ILLEG);
      end else if (state == S_SCAN) begin
        scanReg    <= scanReg << SCAN;
        cntReg     <= cntNext;
        chunksLeft <= chunksLeft - CCW'(1);
        if (scanDone) begin
          resultReg <= {{(XLEN-CW){1'b0}}, cntNext};
          illegReg  <= 1'b0;
        end
      end
    end
  end

  assign dout_rd   = resultReg;
  assign out_illeg = illegReg;

endmodule
